// File: rtl/iter_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : iter_divider_if
//  Purpose  : Start/operand/result bundle for the iterative divider.
//             master = requester (drives start and operands),
//             slave  = divider (drives result, remainder, flags).
//  Revision : 1.0 - initial release
// ============================================================================
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module   : iter_divider
//  Purpose  : Iterative restoring divider, STEPS quotient bits per clock.
//             Quotient/remainder/exception registered on the final edge,
//             with a one-cycle data_resultRDY pulse.
//  Options  : define ITER_DIVIDER_SIGNED_EN for two's-complement operands
//             (truncating division, most-negative/-1 flagged as overflow).
//  Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input wire            clock,
  input wire            reset,
  iter_divider_if.slave bus
);

  localparam int N     = WIDTH / STEPS;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_divisor;
  logic [2*WIDTH-1:0] r_acc;          // {partial remainder, quotient}
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_exception;
  logic               r_rdy;
  logic               r_busy;
  logic               r_dz_pending;   // divide-by-zero start waiting one edge for DONE

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;
  logic               w_exc_final;

  // One restoring step. The bit shifted out of the upper half is kept as
  // the top of a WIDTH+1 bit partial so large unsigned divisors stay exact.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [2*WIDTH-1:0] acc,
    input logic [WIDTH-1:0]   d
  );
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] sh;
    partial = acc[2*WIDTH-1:WIDTH-1];
    diff    = partial - {1'b0, d};
    sh      = {acc[2*WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      sh[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
      sh[0]               = 1'b1;
    end
    return sh;
  endfunction

  // Chain STEPS restoring steps for a single RUN edge
  always_comb begin
    w_acc_next = r_acc;
    for (int s = 0; s < STEPS; s++) begin
      w_acc_next = div_step(w_acc_next, r_divisor);
    end
  end

`ifdef ITER_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf;
  logic w_ovf_start;

  assign w_a_mag     = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign w_b_mag     = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
  assign w_ovf_start = (bus.data_operandA == c_most_neg) && (&bus.data_operandB);
  assign w_q_final   = r_ovf ? c_most_neg
                     : (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
  assign w_r_final   = r_ovf ? '0
                     : (r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH]);
  assign w_exc_final = r_ovf;
`else
  assign w_a_mag     = bus.data_operandA;
  assign w_b_mag     = bus.data_operandB;
  assign w_q_final   = r_acc[WIDTH-1:0];
  assign w_r_final   = r_acc[2*WIDTH-1:WIDTH];
  assign w_exc_final = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_divisor    <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_remainder  <= '0;
      r_exception  <= 1'b0;
      r_rdy        <= 1'b0;
      r_busy       <= 1'b0;
      r_dz_pending <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_ovf        <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      if (bus.ctrl_DIV) begin
        // A start in any state (including RUN = abort) reloads everything
        r_divisor <= w_b_mag;
        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
        r_count   <= CNT_W'(N);
`ifdef ITER_DIVIDER_SIGNED_EN
        r_neg_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_neg_r   <= bus.data_operandA[WIDTH-1];
        r_ovf     <= w_ovf_start;
`endif
        if (bus.data_operandB == '0) begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_dz_pending <= 1'b1;
        end else begin
          r_state      <= RUN;
          r_busy       <= 1'b1;
          r_dz_pending <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (r_dz_pending) begin
              r_state      <= DONE;
              r_dz_pending <= 1'b0;
              r_result     <= '0;
              r_remainder  <= '0;
              r_exception  <= 1'b1;
              r_rdy        <= 1'b1;
            end
          end
          RUN: begin
            if (r_count != '0) begin
              r_acc   <= w_acc_next;
              r_count <= r_count - CNT_W'(1);
            end else begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_rdy       <= 1'b1;
              r_result    <= w_q_final;
              r_remainder <= w_r_final;
              r_exception <= w_exc_final;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_remainder = r_remainder;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_divider
//  Purpose  : Directed self-checking bench for iter_divider (STEPS=1 and 4).
//             Expected values follow ITER_DIVIDER_SIGNED_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_divider;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat, bsy, nrdy, early;

  always #5 clock = ~clock;

  iter_divider_if #(.WIDTH(WIDTH)) if1 ();
  iter_divider_if #(.WIDTH(WIDTH)) if4 ();

  iter_divider #(.WIDTH(WIDTH), .STEPS(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
  iter_divider #(.WIDTH(WIDTH), .STEPS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe dut1 for up to 'limit' edges, sampled 1 time unit after each edge
  task automatic window(input int limit, input bit stop_on_rdy,
                        output int lat_o, output int busy_o, output int rdy_o);
    lat_o = -1; busy_o = 0; rdy_o = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clock); #1;
      if (if1.busy) busy_o++;
      if (if1.data_resultRDY) begin
        rdy_o++;
        if (lat_o < 0) lat_o = k;
        if (stop_on_rdy) break;
      end
    end
  endtask

  // Issue a one-cycle start on dut1 (called 1 unit after an edge), then observe
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int limit,
                        input bit stop_on_rdy, output int lat_o, output int busy_o,
                        output int rdy_o);
    if1.ctrl_DIV = 1'b1; if1.data_operandA = a; if1.data_operandB = b;
    @(posedge clock); #1;
    if1.ctrl_DIV = 1'b0;
    window(limit, stop_on_rdy, lat_o, busy_o, rdy_o);
  endtask

  task automatic expect_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input logic exc,
                           input int exp_lat);
    int l, bc, rc;
    run_op(a, b, 40, 1'b0, l, bc, rc);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_rdycnt"}, rc, 1);
    check({tag, "_q"}, if1.data_result, q);
    check({tag, "_r"}, if1.data_remainder, r);
    check({tag, "_exc"}, if1.data_exception, exc);
  endtask

  initial begin
    if4.ctrl_DIV = 1'b0; if4.data_operandA = '0; if4.data_operandB = '0;
    // Start request held during reset must be ignored
    if1.ctrl_DIV = 1'b1; if1.data_operandA = 32'd100; if1.data_operandB = 32'd7;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", if1.data_result, 0);
    check("rst_rem", if1.data_remainder, 0);
    check("rst_exc", if1.data_exception, 0);
    check("rst_rdy", if1.data_resultRDY, 0);
    check("rst_busy", if1.busy, 0);

    // First edge after reset release accepts 100/7
    reset = 1'b1;
    @(posedge clock); #1;
    if1.ctrl_DIV = 1'b0;
    check("busy_at_start", if1.busy, 1);
    window(40, 1'b0, lat, bsy, nrdy);
    check("d100_7_lat", lat, 33);
    check("d100_7_busy", bsy, 32);
    check("d100_7_rdycnt", nrdy, 1);
    check("d100_7_q", if1.data_result, 14);
    check("d100_7_r", if1.data_remainder, 2);
    check("d100_7_exc", if1.data_exception, 0);

    expect_op("divzero", 32'h1234, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    expect_op("zero_dividend", 32'h0, 32'd5, 32'h0, 32'h0, 1'b0, 33);
    expect_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 33);
`ifdef ITER_DIVIDER_SIGNED_EN
    expect_op("m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    expect_op("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 33);
    expect_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 33);
    expect_op("big_div", 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0, 33);
`else
    expect_op("m7_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h1, 1'b0, 33);
    expect_op("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h7, 1'b0, 33);
    expect_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    expect_op("big_div", 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 32'h7FFF_FFFE, 1'b0, 33);
`endif

    // Abort: 1000/3 restarted at E10 with 50/5
    if1.ctrl_DIV = 1'b1; if1.data_operandA = 32'd1000; if1.data_operandB = 32'd3;
    @(posedge clock); #1;
    if1.ctrl_DIV = 1'b0;
    early = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (if1.data_resultRDY) early++;
    end
    run_op(32'd50, 32'd5, 40, 1'b0, lat, bsy, nrdy);
    check("abort_early_rdy", early, 0);
    check("abort_lat", lat, 33);
    check("abort_rdycnt", nrdy, 1);
    check("abort_q", if1.data_result, 10);
    check("abort_r", if1.data_remainder, 0);

    // Start accepted in DONE while the previous result is still flagged
    run_op(32'd20, 32'd6, 40, 1'b1, lat, bsy, nrdy);
    check("done_first_lat", lat, 33);
    check("done_first_q", if1.data_result, 3);
    check("done_first_r", if1.data_remainder, 2);
    run_op(32'd9, 32'd4, 40, 1'b0, lat, bsy, nrdy);
    check("done_restart_lat", lat, 33);
    check("done_restart_rdycnt", nrdy, 1);
    check("done_restart_q", if1.data_result, 2);
    check("done_restart_r", if1.data_remainder, 1);

    // Reset asserted at E15 of a running operation
    if1.ctrl_DIV = 1'b1; if1.data_operandA = 32'd1000; if1.data_operandB = 32'd3;
    @(posedge clock); #1;
    if1.ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    @(posedge clock);
    reset = 1'b0;
    #1;
    check("midrst_result", if1.data_result, 0);
    check("midrst_rem", if1.data_remainder, 0);
    check("midrst_busy", if1.busy, 0);
    check("midrst_rdy", if1.data_resultRDY, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    window(40, 1'b0, lat, bsy, nrdy);
    check("midrst_no_rdy", nrdy, 0);
    check("midrst_no_busy", bsy, 0);

    // Four steps per clock
    if4.ctrl_DIV = 1'b1; if4.data_operandA = 32'hFFFF_FFFF; if4.data_operandB = 32'h10;
    @(posedge clock); #1;
    if4.ctrl_DIV = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (if4.data_resultRDY && lat < 0) lat = k;
    end
    check("s4_lat", lat, 9);
`ifdef ITER_DIVIDER_SIGNED_EN
    check("s4_q", if4.data_result, 32'h0);
    check("s4_r", if4.data_remainder, 32'hFFFF_FFFF);
`else
    check("s4_q", if4.data_result, 32'h0FFF_FFFF);
    check("s4_r", if4.data_remainder, 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
